// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch input front end: FSM state encoding,
// default timing constants and direction levels.
package stopwatch_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;

  localparam int unsigned DEBOUNCE_CYCLES_DEF   = 100000;
  localparam int unsigned LONG_PRESS_CYCLES_DEF = 50000000;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/stopwatch_btn_ctrl_btn_debounce.sv
// One raw board input: 2-flop synchroniser, debouncer and rising-edge pulse.
// The level only flips after the synchronised value has disagreed with it for
// DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Mismatch counter: flip the level on the last consecutive mismatching cycle
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, debounce state and previous level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign pulse_o = level_q & ~prev_q;

endmodule

// File: rtl/stopwatch_btn_ctrl.sv
// Stopwatch button front end: debounces start/stop/clear buttons and the
// direction switch, arbitrates press events in an IDLE/RUN/PAUSE FSM and
// emits registered one-cycle start/stop/clr pulses plus a held-off dir level.
// Optional feature macro: LONG_PRESS_CLR_EN (holding btn_stop issues a clear).
module stopwatch_btn_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_start,
  input  logic btn_stop,
  input  logic btn_clr,
  input  logic sw_dir,
  output logic start,
  output logic stop,
  output logic clr,
  output logic dir,
  output logic running
);

  logic [3:0] raw, lvl, rise;
  logic       rise_start, rise_stop, rise_clr;
  logic       lvl_stop, lvl_dir;
  logic       clr_evt;
  logic       unused_bits;

  assign raw = {sw_dir, btn_clr, btn_stop, btn_start};

  for (genvar g = 0; g < 4; g++) begin : g_in
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (raw[g]),
      .level_o(lvl[g]),
      .pulse_o(rise[g])
    );
  end

  assign rise_start = rise[0];
  assign rise_stop  = rise[1];
  assign rise_clr   = rise[2];
  assign lvl_stop   = lvl[1];
  assign lvl_dir    = lvl[3];

`ifdef LONG_PRESS_CLR_EN
  localparam int unsigned LCW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [LCW-1:0] HOLD_MAX  = LCW'(LONG_PRESS_CYCLES);
  localparam logic [LCW-1:0] HOLD_FIRE = LCW'(LONG_PRESS_CYCLES - 1);

  logic [LCW-1:0] hold_q;
  logic           long_q;

  // Hold counter saturates so a continued hold fires only once per press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      long_q <= lvl_stop && (hold_q == HOLD_FIRE);
      if (!lvl_stop) begin
        hold_q <= '0;
      end else if (hold_q != HOLD_MAX) begin
        hold_q <= hold_q + 1'b1;
      end
    end
  end

  assign clr_evt     = rise_clr | long_q;
  assign unused_bits = ^{lvl[2], lvl[0], rise[3]};
`else
  assign clr_evt     = rise_clr;
  assign unused_bits = ^{lvl[2:0], rise[3], 32'(LONG_PRESS_CYCLES)};
`endif

  state_t state_q, state_d;
  logic   start_q, start_d;
  logic   stop_q, stop_d;
  logic   clr_q, clr_d;
  logic   dir_q, dir_d;

  // Event arbitration: the highest-priority event present wins even when the
  // current state ignores it, so a lower one in the same cycle is dropped
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    clr_d   = 1'b0;
    dir_d   = (state_q != ST_RUN) ? lvl_dir : dir_q;
    if (clr_evt) begin
      state_d = ST_IDLE;
      clr_d   = 1'b1;
    end else if (rise_stop) begin
      if (state_q == ST_RUN) begin
        state_d = ST_PAUSE;
        stop_d  = 1'b1;
      end
    end else if (rise_start) begin
      if (state_q != ST_RUN) begin
        state_d = ST_RUN;
        start_d = 1'b1;
      end
    end
  end

  // FSM state, output pulses and direction register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      clr_q   <= 1'b0;
      dir_q   <= DIR_UP;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      clr_q   <= clr_d;
      dir_q   <= dir_d;
    end
  end

  assign start   = start_q;
  assign stop    = stop_q;
  assign clr     = clr_q;
  assign dir     = dir_q;
  assign running = (state_q == ST_RUN);

endmodule
